uart_csr_bank: RTL and testbench
================================

Name: uart_csr_bank

Overview:
- Multi-channel, parameterised control/status register bank serving NUM_CH UART channels from one CSR port.
- Holds per-channel baud divisor, control, sticky status and interrupt enable.
- Aggregates channel events into per-channel and global interrupts.
- Reads return registered data with a valid/error response, so the bus can detect unmapped and illegal accesses.

Parameters:
- NUM_CH, 4: number of UART channels (1..16).
- DATA_W, 32: CSR data width (>=16).
- ADDR_W, 8: word address width; must satisfy 2^ADDR_W > 4*NUM_CH.
- BAUD_RST, 434: reset baud divisor (50 MHz / 115200).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_addr  in  ADDR_W  write word address
- wr_data  in  DATA_W  write data
- wen  in  1  write strobe, one access per cycle
- rd_addr  in  ADDR_W  read word address
- ren  in  1  read strobe
- rd_data  out  DATA_W  read data, valid with rd_valid
- rd_valid  out  1  read response pulse
- rd_err  out  1  read to unmapped address, qualified by rd_valid
- wr_err  out  1  write rejected (unmapped, RO or locked), 1-cycle pulse
- baud_div  out  NUM_CH*16  per-channel divisor, channel c at [16c+15:16c]
- ctrl  out  NUM_CH*8  per-channel control byte
- parity_err_evt  in  NUM_CH  1-cycle parity error pulse per channel
- frame_err_evt  in  NUM_CH  1-cycle framing error pulse
- overrun_evt  in  NUM_CH  1-cycle RX overrun pulse
- busy  in  NUM_CH  channel became busy (pulse)
- free  in  NUM_CH  channel became free (pulse)
- irq  out  NUM_CH  per-channel interrupt, registered
- irq_any  out  1  OR of irq, registered

Behaviour:
- Clock/reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - Registers: BAUD=BAUD_RST, CTRL=0x08, STATUS=0, IRQ_EN=0.
  - Outputs: rd_data=0, rd_valid=0, rd_err=0, wr_err=0, irq=0, irq_any=0.
  - Reset mid-access aborts the access; no response is issued.
- Address map (word address):
  - Channel c at base 4c: +0 BAUD (RW, bits[15:0]), +1 CTRL (RW, bits[7:0]), +2 STATUS (RO, read-clear), +3 IRQ_EN (RW, bits[3:0]).
  - Address 4*NUM_CH: IRQ_PEND (RO, bit c = irq[c]).
  - All other addresses are unmapped.
  - Unused upper bits read 0 and ignore writes.
- CTRL fields: [3:0] data_bits, [4] parity_en, [5] parity_odd, [6] two_stop, [7] enable.
- STATUS fields:
  - [0] data_bits_err, [1] parity_err, [2] frame_err, [3] overrun: all sticky.
  - [4] busy: live state, not cleared by read.
- Writes:
  - Take effect at the clk edge where wen=1.
  - A write to an RO or unmapped address changes nothing and pulses wr_err on the next cycle.
- Reads:
  - rd_valid pulses exactly 1 cycle after ren and carries rd_data.
  - An unmapped read returns rd_data=0 with rd_err=1.
  - Reads of RW/RO registers never change them, except that a STATUS read clears that channel's sticky bits [3:0].
- Same-cycle read and write to one register: the write commits and the read returns the pre-write value.
- Sticky set vs read-clear in the same cycle: the set wins and the bit stays 1, so no event is lost.
- data_bits_err:
  - Set every cycle the registered data_bits is outside 5..8.
  - After a clearing read it reasserts 1 cycle later if the condition persists.
- Busy tracking: a busy pulse sets busy and a free pulse clears it; busy takes priority if both pulse together.
- Interrupts:
  - irq[c] is registered: irq[c] = |(STATUS[c][3:0] & IRQ_EN[c][3:0]).
  - irq rises 1 cycle after the sticky bit sets, and irq_any follows in the same cycle.
- Per-channel event inputs are independent; all channels update in parallel every cycle.

Optional Feature:
- UART_CSR_WRITE_LOCK_EN defined:
  - While STATUS[c].busy=1, writes to channel c BAUD, or to CTRL bits[6:0], are rejected and wr_err pulses.
  - CTRL.enable remains writable.
- Undefined: all RW writes are always accepted.

Test Plan:
- Reset -> BAUD ch0..3 read 434 (0x1B2), CTRL reads 0x08, STATUS 0, irq=0; each read gives rd_valid exactly 1 cycle after ren.
- Write CTRL ch2 = 0x03 -> data_bits_err sets; IRQ_EN ch2 = 0x1 -> irq[2]=1, irq_any=1; a STATUS ch2 read returns 0x01, then the bit reasserts the next cycle.
- Pulse parity_err_evt[1] in the same cycle as a STATUS ch1 read -> that read returns 0; the next read returns 0x02, and the read after that returns 0x00.
- Read address 0x40 (NUM_CH=4) -> rd_data=0, rd_err=1; write to STATUS ch0 -> wr_err pulses, register unchanged.
- busy[3] and free[3] pulsed together -> STATUS ch3 bit4=1; a later free[3] pulse -> bit4=0.
- UART_CSR_WRITE_LOCK_EN defined, ch0 busy, write BAUD=0x0010 -> wr_err=1 and BAUD stays 434; after free[0] the same write is accepted.

Source files
------------

// File: rtl/uart_csr_bank.sv
// uart_csr_bank: per-channel UART CSRs (baud, ctrl, sticky status, irq enable) with irq aggregation.
// Optional: define UART_CSR_WRITE_LOCK_EN to block BAUD and CTRL[6:0] writes while a channel is busy.
module uart_csr_bank #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned BAUD_RST = 434
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 wen,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic                 ren,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic                 rd_err,
    output logic                 wr_err,
    output logic [NUM_CH*16-1:0] baud_div,
    output logic [NUM_CH*8-1:0]  ctrl,
    input  logic [NUM_CH-1:0]    parity_err_evt,
    input  logic [NUM_CH-1:0]    frame_err_evt,
    input  logic [NUM_CH-1:0]    overrun_evt,
    input  logic [NUM_CH-1:0]    busy,
    input  logic [NUM_CH-1:0]    free,
    output logic [NUM_CH-1:0]    irq,
    output logic                 irq_any
);
    localparam logic [ADDR_W-1:0] PEND_ADDR = ADDR_W'(4 * NUM_CH);
    localparam logic [15:0]       BAUD_INIT = 16'(BAUD_RST);

    logic [15:0]       baud_q   [NUM_CH];
    logic [7:0]        ctrl_q   [NUM_CH];
    logic [3:0]        sticky_q [NUM_CH];
    logic [3:0]        ien_q    [NUM_CH];
    logic [NUM_CH-1:0] busy_q, irq_q, lock, dbits_bad, irq_next;
    logic [NUM_CH-1:0] we_baud, we_ctrl, we_ien, rd_stat;
    logic              wr_rej, rd_miss;
    logic [DATA_W-1:0] rd_next;

    if (DATA_W > 16) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^wr_data[DATA_W-1:16];
    end

`ifdef UART_CSR_WRITE_LOCK_EN
    assign lock = busy_q;
`else
    assign lock = '0;
`endif

    // wr_rej starts as "rejected" and is cleared only by an accepting RW decode
    always_comb begin
        we_baud = '0;
        we_ctrl = '0;
        we_ien  = '0;
        wr_rej  = wen;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (wr_addr == ADDR_W'(4 * c)) begin
                we_baud[c] = wen & ~lock[c];
                wr_rej     = wen & lock[c];
            end
            if (wr_addr == ADDR_W'(4 * c + 1)) begin
                we_ctrl[c] = wen;
                wr_rej     = wen & lock[c] & (wr_data[6:0] != ctrl_q[c][6:0]);
            end
            if (wr_addr == ADDR_W'(4 * c + 3)) begin
                we_ien[c] = wen;
                wr_rej    = 1'b0;
            end
        end
    end

    always_comb begin
        rd_next = '0;
        rd_miss = 1'b1;
        rd_stat = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rd_addr == ADDR_W'(4 * c)) begin
                rd_next[15:0] = baud_q[c];
                rd_miss       = 1'b0;
            end
            if (rd_addr == ADDR_W'(4 * c + 1)) begin
                rd_next[7:0] = ctrl_q[c];
                rd_miss      = 1'b0;
            end
            if (rd_addr == ADDR_W'(4 * c + 2)) begin
                rd_next[4:0] = {busy_q[c], sticky_q[c]};
                rd_miss      = 1'b0;
                rd_stat[c]   = ren;
            end
            if (rd_addr == ADDR_W'(4 * c + 3)) begin
                rd_next[3:0] = ien_q[c];
                rd_miss      = 1'b0;
            end
        end
        if (rd_addr == PEND_ADDR) begin
            rd_next[NUM_CH-1:0] = irq_q;
            rd_miss             = 1'b0;
        end
    end

    always_comb begin
        dbits_bad = '0;
        irq_next  = '0;
        baud_div  = '0;
        ctrl      = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            dbits_bad[c]         = (ctrl_q[c][3:0] < 4'd5) || (ctrl_q[c][3:0] > 4'd8);
            irq_next[c]          = |(sticky_q[c] & ien_q[c]);
            baud_div[16*c +: 16] = baud_q[c];
            ctrl[8*c +: 8]       = ctrl_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                baud_q[c]   <= BAUD_INIT;
                ctrl_q[c]   <= 8'h08;
                sticky_q[c] <= '0;
                ien_q[c]    <= '0;
            end
            busy_q   <= '0;
            irq_q    <= '0;
            irq_any  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (we_baud[c]) baud_q[c] <= wr_data[15:0];
                if (we_ctrl[c]) ctrl_q[c] <= lock[c] ? {wr_data[7], ctrl_q[c][6:0]} : wr_data[7:0];
                if (we_ien[c])  ien_q[c]  <= wr_data[3:0];
                // event bits: set beats read-clear; data_bits_err: clear wins, re-sets next cycle
                sticky_q[c][3:1] <= (sticky_q[c][3:1] & {3{~rd_stat[c]}})
                                  | {overrun_evt[c], frame_err_evt[c], parity_err_evt[c]};
                sticky_q[c][0]   <= ~rd_stat[c] & (sticky_q[c][0] | dbits_bad[c]);
            end
            busy_q   <= busy | (busy_q & ~free);
            irq_q    <= irq_next;
            irq_any  <= |irq_next;
            rd_valid <= ren;
            rd_err   <= ren & rd_miss;
            wr_err   <= wr_rej;
            if (ren) rd_data <= rd_next;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_uart_csr_bank.sv
// tb_uart_csr_bank: directed + random stimulus against an address-arithmetic reference model.
module tb_uart_csr_bank;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 8;
`ifdef UART_CSR_WRITE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     wr_addr = '0, rd_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              wen = 1'b0, ren = 1'b0;
    logic [DW-1:0]     rd_data;
    logic              rd_valid, rd_err, wr_err, irq_any;
    logic [NCH*16-1:0] baud_div;
    logic [NCH*8-1:0]  ctrl;
    logic [NCH-1:0]    parity_err_evt = '0, frame_err_evt = '0, overrun_evt = '0;
    logic [NCH-1:0]    busy = '0, free = '0, irq;

    uart_csr_bank #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .BAUD_RST(434)) dut (
        .clk(clk), .rst_n(rst_n), .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen),
        .rd_addr(rd_addr), .ren(ren), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_err(rd_err), .wr_err(wr_err), .baud_div(baud_div), .ctrl(ctrl),
        .parity_err_evt(parity_err_evt), .frame_err_evt(frame_err_evt),
        .overrun_evt(overrun_evt), .busy(busy), .free(free), .irq(irq), .irq_any(irq_any)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int m_baud[NCH], m_ctrl[NCH], m_stk[NCH], m_ien[NCH], m_busy[NCH], m_irq[NCH];
    logic [DW-1:0] last_rd;
    logic          last_err, last_wr_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_baud[c] = 434; m_ctrl[c] = 8; m_stk[c] = 0;
            m_ien[c] = 0; m_busy[c] = 0; m_irq[c] = 0;
        end
    endtask

    // One clock: predict from pre-edge model state, step the model, compare after the edge.
    task automatic tick();
        int ra, wa, ch, r, e_rd, pend, evt, keep, b0;
        int unsigned wd;
        bit e_err, e_wre, lk, clr, bad;
        int n_baud[NCH], n_ctrl[NCH], n_stk[NCH], n_ien[NCH], n_busy[NCH], n_irq[NCH];
        ra = int'(rd_addr); wa = int'(wr_addr); wd = wr_data;
        pend = 0;
        for (int c = 0; c < NCH; c++) pend += m_irq[c] << c;
        e_rd = 0; e_err = 1'b0;
        if (ren) begin
            if (ra < 4 * NCH) begin
                ch = ra / 4; r = ra % 4;
                case (r)
                    0: e_rd = m_baud[ch];
                    1: e_rd = m_ctrl[ch];
                    2: e_rd = m_busy[ch] * 16 + m_stk[ch];
                    default: e_rd = m_ien[ch];
                endcase
            end else if (ra == 4 * NCH) e_rd = pend;
            else e_err = 1'b1;
        end
        n_baud = m_baud; n_ctrl = m_ctrl; n_ien = m_ien;
        for (int c = 0; c < NCH; c++) begin
            n_busy[c] = busy[c] ? 1 : (free[c] ? 0 : m_busy[c]);
            clr  = ren && (ra == 4 * c + 2);
            bad  = (m_ctrl[c] % 16 < 5) || (m_ctrl[c] % 16 > 8);
            keep = clr ? 0 : m_stk[c];
            b0   = clr ? 0 : (((keep % 2) == 1 || bad) ? 1 : 0);
            evt  = int'(parity_err_evt[c]) + 2 * int'(frame_err_evt[c]) + 4 * int'(overrun_evt[c]);
            n_stk[c] = b0 + 2 * (((keep / 2) % 8) | evt);
            n_irq[c] = ((m_stk[c] & m_ien[c]) != 0) ? 1 : 0;
        end
        e_wre = 1'b0;
        if (wen) begin
            if (wa >= 4 * NCH) e_wre = 1'b1;
            else begin
                ch = wa / 4; r = wa % 4;
                lk = LOCK && (m_busy[ch] == 1);
                case (r)
                    0: if (lk) e_wre = 1'b1; else n_baud[ch] = int'(wd % 65536);
                    1: if (lk) begin
                           n_ctrl[ch] = int'(wd & 128) + (m_ctrl[ch] % 128);
                           if (int'(wd % 128) != m_ctrl[ch] % 128) e_wre = 1'b1;
                       end else n_ctrl[ch] = int'(wd % 256);
                    2: e_wre = 1'b1;
                    default: n_ien[ch] = int'(wd % 16);
                endcase
            end
        end
        @(posedge clk); #1;
        m_baud = n_baud; m_ctrl = n_ctrl; m_stk = n_stk;
        m_ien = n_ien; m_busy = n_busy; m_irq = n_irq;
        pend = 0;
        for (int c = 0; c < NCH; c++) pend += m_irq[c] << c;
        chk("rd_valid", 32'(rd_valid), 32'(ren));
        if (ren) begin
            chk("rd_data", rd_data, e_rd);
            chk("rd_err", 32'(rd_err), 32'(e_err));
        end
        chk("wr_err", 32'(wr_err), 32'(e_wre));
        chk("irq", 32'(irq), pend);
        chk("irq_any", 32'(irq_any), 32'(pend != 0));
        for (int c = 0; c < NCH; c++) begin
            chk("baud_div", 32'(baud_div[16*c +: 16]), m_baud[c]);
            chk("ctrl", 32'(ctrl[8*c +: 8]), m_ctrl[c]);
        end
        last_rd = rd_data; last_err = rd_err; last_wr_err = wr_err;
        ren = 1'b0; wen = 1'b0;
        parity_err_evt = '0; frame_err_evt = '0; overrun_evt = '0; busy = '0; free = '0;
    endtask

    task automatic rd(input int a);
        ren = 1'b1; rd_addr = AW'(a); tick();
    endtask

    task automatic wr(input int a, input int unsigned d);
        wen = 1'b1; wr_addr = AW'(a); wr_data = d; tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_irq_any", 32'(irq_any), 0);
        chk("rst_wr_err", 32'(wr_err), 0);
        rst_n = 1'b1;

        for (int c = 0; c < NCH; c++) begin
            rd(4 * c); chk("baud_rst", last_rd, 32'h1B2);
        end
        rd(1); chk("ctrl_rst", last_rd, 32'h08);
        rd(2); chk("status_rst", last_rd, 0);

        // data_bits_err on channel 2 and its interrupt
        wr(9, 32'h03);
        wr(11, 32'h1);
        tick();
        chk("irq2", 32'(irq[2]), 1);
        chk("irq_any2", 32'(irq_any), 1);
        rd(10); chk("dbits_read", last_rd, 32'h01);
        tick();
        rd(10); chk("dbits_reassert", last_rd, 32'h01);
        wr(9, 32'h08); wr(11, 32'h0);
        tick(); rd(10); tick(); tick();

        // event coinciding with a clearing read is not lost
        parity_err_evt[1] = 1'b1; rd(6); chk("par_same", last_rd, 0);
        rd(6); chk("par_next", last_rd, 32'h02);
        rd(6); chk("par_clr", last_rd, 0);

        rd(8'h40); chk("unmap_data", last_rd, 0); chk("unmap_err", 32'(last_err), 1);
        wr(2, 32'hF); chk("ro_wr_err", 32'(last_wr_err), 1);
        rd(2); chk("ro_unchanged", last_rd, 0);

        busy[3] = 1'b1; free[3] = 1'b1; tick();
        rd(14); chk("busy_prio", last_rd, 32'h10);
        free[3] = 1'b1; tick();
        rd(14); chk("busy_free", last_rd, 0);

        busy[0] = 1'b1; tick();
        wr(0, 32'h10);
`ifdef UART_CSR_WRITE_LOCK_EN
        chk("lock_wr_err", 32'(last_wr_err), 1);
        rd(0); chk("lock_baud", last_rd, 32'h1B2);
        free[0] = 1'b1; tick();
        wr(0, 32'h10); chk("unlock_wr_err", 32'(last_wr_err), 0);
`else
        chk("nolock_wr_err", 32'(last_wr_err), 0);
`endif
        rd(0); chk("baud_written", last_rd, 32'h10);
        free[0] = 1'b1; tick();

        for (int i = 0; i < 600; i++) begin
            ren = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 4 * NCH + 3));
            wen = ($urandom_range(0, 2) == 0);
            wr_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 4 * NCH + 3));
            wr_data = $urandom;
            if ($urandom_range(0, 1) == 1) wr_data[3:0] = 4'($urandom_range(5, 8));
            parity_err_evt = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
            frame_err_evt  = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
            overrun_evt    = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
            busy           = NCH'($urandom) & NCH'($urandom);
            free           = NCH'($urandom) & NCH'($urandom);
            tick();
        end

        // reset during a read: no response
        ren = 1'b1; rd_addr = '0; rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_abort_valid", 32'(rd_valid), 0);
        ren = 1'b0; rst_n = 1'b1;
        model_reset();
        tick();
        rd(1); chk("ctrl_after_rst", last_rd, 32'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
